// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder: FSM states, data/address
// widths and the set of byte-enable patterns the responder accepts.
package mem_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_BITS  = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [BE_WIDTH-1:0] BE_BYTE0 = 4'b0001;
    localparam logic [BE_WIDTH-1:0] BE_BYTE1 = 4'b0010;
    localparam logic [BE_WIDTH-1:0] BE_BYTE2 = 4'b0100;
    localparam logic [BE_WIDTH-1:0] BE_BYTE3 = 4'b1000;
    localparam logic [BE_WIDTH-1:0] BE_HALF0 = 4'b0011;
    localparam logic [BE_WIDTH-1:0] BE_HALF1 = 4'b1100;
    localparam logic [BE_WIDTH-1:0] BE_WORD  = 4'b1111;

    // Only naturally aligned byte, halfword and word lane patterns are legal.
    function automatic logic be_legal(input logic [BE_WIDTH-1:0] be);
        logic ok;
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3,
            BE_HALF0, BE_HALF1, BE_WORD: ok = 1'b1;
            default:                     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sram_be.sv
// Single-port word memory with per-byte write enables and a registered read
// port. The read register only updates on an enabled load.
module sram_be
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic [3:0]            be,
    output logic [31:0]           rdata
);

    logic [DATA_WIDTH-1:0] mem_q [0:(1 << ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_d;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_comb begin
        rdata_d = rdata_q;
        if (en && !we) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clock) begin
        rdata_q <= rdata_d;
        if (en && we) begin
            for (int i = 0; i < BE_WIDTH; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder: accepts one CPU request at a time,
// checks it for range/byte-enable faults and answers after LATENCY cycles.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        req_ready,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    logic        err_d, err_q;
    logic        load_d, load_q;

    logic        accept;
    logic        range_fault;
    logic        be_fault;
    logic        fault;
    logic [31:0] sram_rdata;
    logic        unused_addr_bits;

    // Reset beats a simultaneous request, so it also blocks the memory write.
    assign accept      = req_valid && (state_q == ST_IDLE) && !reset;
    assign range_fault = |req_addr[ADDR_BITS-1:ADDR_WIDTH+2];
    assign be_fault    = !be_legal(req_be);
    assign fault       = range_fault || be_fault;
    assign unused_addr_bits = ^req_addr[1:0];

    sram_be #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clock (clock),
        .en    (accept && !fault),
        .we    (req_write),
        .addr  (req_addr[ADDR_WIDTH+1:2]),
        .wdata (req_wdata),
        .be    (req_be),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        load_d  = load_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_WAIT;
                    cnt_d   = LAT_M1;
                    err_d   = fault;
                    load_d  = !req_write && !fault;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // The SRAM read register is untouched until the next accept, so it holds the load data.
    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_error = resp_valid && err_q;
    assign resp_rdata = (resp_valid && load_q) ? sram_rdata : 32'd0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a behavioural memory model feeds a
// scoreboard queue that is checked as each response appears.
module tb_data_mem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_error;

    logic        l1_req_valid, l1_req_write, l1_req_ready;
    logic [31:0] l1_req_addr, l1_req_wdata, l1_resp_rdata;
    logic [3:0]  l1_req_be;
    logic        l1_resp_valid, l1_resp_ready, l1_resp_error;

    exp_t        sb_q[$];
    logic [31:0] model [0:(1 << AW)-1];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] last_rdata;
    logic        last_err;

    always #5 clock = ~clock;

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_be     (req_be),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    data_mem_responder #(.ADDR_WIDTH(AW), .LATENCY(1)) dut_l1 (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (l1_req_valid),
        .req_write  (l1_req_write),
        .req_addr   (l1_req_addr),
        .req_wdata  (l1_req_wdata),
        .req_be     (l1_req_be),
        .req_ready  (l1_req_ready),
        .resp_valid (l1_resp_valid),
        .resp_ready (l1_resp_ready),
        .resp_rdata (l1_resp_rdata),
        .resp_error (l1_resp_error)
    );

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference behaviour: fault detection and byte-lane store into the model.
    function automatic exp_t model_access(input logic wr, input logic [31:0] addr,
                                          input logic [31:0] wdata, input logic [3:0] be);
        exp_t e;
        logic legal_be;
        logic bad;
        int   idx;
        legal_be = (be == 4'b0001) || (be == 4'b0010) || (be == 4'b0100) ||
                   (be == 4'b1000) || (be == 4'b0011) || (be == 4'b1100) ||
                   (be == 4'b1111);
        bad = (addr[31:AW+2] != '0) || !legal_be;
        idx = int'(addr[AW+1:2]);
        e.err   = bad;
        e.rdata = 32'd0;
        if (!bad) begin
            if (wr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) model[idx][8*i +: 8] = wdata[8*i +: 8];
                end
            end else begin
                e.rdata = model[idx];
            end
        end
        return e;
    endfunction

    task automatic apply_stimulus(input logic wr, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [3:0] be,
                                  input int hold, input logic stray);
        exp_t e;
        int   n;
        @(negedge clock);
        check_output("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        sb_q.push_back(model_access(wr, addr, wdata, be));
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!resp_valid && n < 20);
        check_output("resp_latency", n, LAT);
        e = sb_q.pop_front();
        check_output("resp_rdata", resp_rdata, e.rdata);
        check_output("resp_error", {31'd0, resp_error}, {31'd0, e.err});
        last_rdata = resp_rdata;
        last_err   = resp_error;
        for (int c = 0; c < hold; c++) begin
            if (stray) begin
                req_valid = 1'b1;
                req_write = 1'b1;
                req_addr  = addr;
                req_wdata = 32'h5555_5555;
                req_be    = 4'b1111;
            end
            @(posedge clock);
            #1;
            check_output("hold_resp_valid", {31'd0, resp_valid}, 32'd1);
            check_output("hold_resp_rdata", resp_rdata, e.rdata);
            check_output("hold_req_ready", {31'd0, req_ready}, 32'd0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check_output("post_hs_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("post_hs_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("post_hs_rdata", resp_rdata, 32'd0);
    endtask

    // LATENCY=1 instance: issued immediately after the previous handshake.
    task automatic l1_stimulus(input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] exp_rdata);
        exp_t e;
        int   n;
        check_output("l1_req_ready", {31'd0, l1_req_ready}, 32'd1);
        e.rdata = exp_rdata;
        e.err   = 1'b0;
        sb_q.push_back(e);
        l1_req_valid = 1'b1;
        l1_req_write = wr;
        l1_req_addr  = addr;
        l1_req_wdata = wdata;
        l1_req_be    = 4'b1111;
        @(posedge clock);
        #1;
        l1_req_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (!l1_resp_valid && n < 20);
        check_output("l1_latency", n, 1);
        e = sb_q.pop_front();
        check_output("l1_rdata", l1_resp_rdata, e.rdata);
        check_output("l1_error", {31'd0, l1_resp_error}, {31'd0, e.err});
        @(posedge clock);
        #1;
        check_output("l1_post_hs_valid", {31'd0, l1_resp_valid}, 32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        req_be       = 4'd0;
        resp_ready   = 1'b0;
        l1_req_valid = 1'b0;
        l1_req_write = 1'b0;
        l1_req_addr  = 32'd0;
        l1_req_wdata = 32'd0;
        l1_req_be    = 4'd0;
        l1_resp_ready = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        check_output("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("rst_resp_rdata", resp_rdata, 32'd0);
        check_output("rst_resp_error", {31'd0, resp_error}, 32'd0);
        reset = 1'b0;

        $display("[TB] full-word store then load");
        apply_stimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, 1'b0);
        check_output("store_err", {31'd0, last_err}, 32'd0);
        apply_stimulus(1'b0, 32'h10, 32'd0, 4'b1111, 0, 1'b0);
        check_output("load_deadbeef", last_rdata, 32'hDEAD_BEEF);

        $display("[TB] byte-lane merge");
        apply_stimulus(1'b1, 32'h10, 32'h0000_AB00, 4'b0010, 0, 1'b0);
        apply_stimulus(1'b0, 32'h10, 32'd0, 4'b1111, 0, 1'b0);
        check_output("load_merged", last_rdata, 32'hDEAD_ABEF);
        apply_stimulus(1'b0, 32'h13, 32'd0, 4'b1111, 0, 1'b0);
        check_output("load_low_bits_ignored", last_rdata, 32'hDEAD_ABEF);

        $display("[TB] faults");
        apply_stimulus(1'b0, 32'h0000_1000, 32'd0, 4'b1111, 0, 1'b0);
        check_output("range_err", {31'd0, last_err}, 32'd1);
        check_output("range_rdata", last_rdata, 32'd0);
        apply_stimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 4'b0101, 0, 1'b0);
        check_output("be_err", {31'd0, last_err}, 32'd1);
        apply_stimulus(1'b0, 32'h10, 32'd0, 4'b1111, 0, 1'b0);
        check_output("be_fault_no_write", last_rdata, 32'hDEAD_ABEF);

        $display("[TB] backpressure with stray request");
        apply_stimulus(1'b0, 32'h10, 32'd0, 4'b1111, 5, 1'b1);
        apply_stimulus(1'b0, 32'h10, 32'd0, 4'b1111, 0, 1'b0);
        check_output("stray_not_accepted", last_rdata, 32'hDEAD_ABEF);

        $display("[TB] reset during WAIT");
        @(negedge clock);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h1234_5678;
        req_be    = 4'b1111;
        model[8]  = 32'h1234_5678;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_output("wait_rst_req_ready", {31'd0, req_ready}, 32'd1);
        check_output("wait_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check_output("wait_rst_rdata", resp_rdata, 32'd0);
        check_output("wait_rst_error", {31'd0, resp_error}, 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            check_output("wait_rst_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        apply_stimulus(1'b0, 32'h20, 32'd0, 4'b1111, 0, 1'b0);
        check_output("store_survives_reset", last_rdata, 32'h1234_5678);

        $display("[TB] reset together with req_valid");
        @(negedge clock);
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFE_F00D;
        req_be    = 4'b1111;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        check_output("rst_win_req_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) begin
            @(posedge clock);
            #1;
            check_output("rst_win_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        apply_stimulus(1'b0, 32'h20, 32'd0, 4'b1111, 0, 1'b0);
        check_output("rst_win_no_store", last_rdata, 32'h1234_5678);

        $display("[TB] LATENCY=1 back-to-back");
        @(negedge clock);
        l1_stimulus(1'b1, 32'h0C, 32'h0BAD_F00D, 32'd0);
        l1_stimulus(1'b1, 32'h10, 32'h1111_2222, 32'd0);
        l1_stimulus(1'b0, 32'h0C, 32'd0, 32'h0BAD_F00D);
        l1_stimulus(1'b0, 32'h10, 32'd0, 32'h1111_2222);
        l1_stimulus(1'b0, 32'h0C, 32'd0, 32'h0BAD_F00D);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
